// File: rtl/boreal_uart_tx_framer.sv
// boreal_uart_tx_framer: serialises a 9-byte MMIO read-response frame
// (0xAA, cmd, addr, data, xor checksum) onto an 8N1 UART line.
module boreal_uart_tx_framer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_data,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [3:0]    r_byte_idx;
    logic [7:0]    r_cmd;
    logic [9:0]    r_addr;
    logic [31:0]   r_data;
    logic [7:0]    r_chk;
    logic          r_frame_done;
    logic          w_accept;
    logic          w_bit_end;
    logic          w_last_byte;
    logic [7:0]    w_byte;

    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign frame_done  = r_frame_done;
    assign w_accept    = req_valid && req_ready;
    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign w_last_byte = (r_byte_idx == 4'd8);

    always_comb begin
        w_byte = r_chk;
        case (r_byte_idx)
            4'd0:    w_byte = 8'hAA;
            4'd1:    w_byte = r_cmd;
            4'd2:    w_byte = {6'b0, r_addr[9:8]};
            4'd3:    w_byte = r_addr[7:0];
            4'd4:    w_byte = r_data[31:24];
            4'd5:    w_byte = r_data[23:16];
            4'd6:    w_byte = r_data[15:8];
            4'd7:    w_byte = r_data[7:0];
            default: w_byte = r_chk;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = w_byte[r_bit_idx];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_accept) w_next = START;
            START: if (w_bit_end) w_next = DATA;
            DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_next = STOP;
            STOP:  if (w_bit_end) w_next = w_last_byte ? IDLE : START;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_frame_done <= 1'b0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_chk        <= '0;
        end else begin
            r_frame_done <= (r_state == STOP) && w_bit_end && w_last_byte;
            if (r_state == IDLE) begin
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
                if (w_accept) begin
                    r_cmd  <= req_cmd;
                    r_addr <= req_addr;
                    r_data <= req_data;
                    // checksum covers every byte after the 0xAA sync
                    r_chk  <= req_cmd ^ {6'b0, req_addr[9:8]} ^ req_addr[7:0]
                            ^ req_data[31:24] ^ req_data[23:16]
                            ^ req_data[15:8] ^ req_data[7:0];
                end
            end else begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
                if (r_state == DATA && w_bit_end) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                if (r_state == STOP && w_bit_end) begin
                    r_byte_idx <= w_last_byte ? 4'd0 : r_byte_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boreal_uart_tx_framer.sv
// tb_boreal_uart_tx_framer: randomized self-checking bench comparing the
// serial line against a per-cycle waveform built from the frame format.
module tb_boreal_uart_tx_framer;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 125_000;
    localparam int BD        = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = 90 * BD;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [9:0]  req_addr;
    logic [31:0] req_data;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic       wave[FRAME];
    logic [7:0] got[9];

    boreal_uart_tx_framer #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] model_byte(input logic [7:0] cmd,
                                              input logic [9:0] addr,
                                              input logic [31:0] data,
                                              input int k);
        logic [7:0] b[9];
        b[0] = 8'hAA;
        b[1] = cmd;
        b[2] = {6'b0, addr[9:8]};
        b[3] = addr[7:0];
        b[4] = data[31:24];
        b[5] = data[23:16];
        b[6] = data[15:8];
        b[7] = data[7:0];
        b[8] = 8'h00;
        for (int i = 1; i < 8; i++) b[8] = b[8] ^ b[i];
        return b[k];
    endfunction

    function automatic logic model_tx(input logic [7:0] cmd,
                                      input logic [9:0] addr,
                                      input logic [31:0] data,
                                      input int c);
        int k;
        int j;
        logic [7:0] by;
        k = c / (10 * BD);
        j = (c / BD) % 10;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        by = model_byte(cmd, addr, data, k);
        return by[j-1];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] cmd, input logic [9:0] addr,
                           input logic [31:0] data);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_data  = data;
        step();
        req_valid = 1'b0;
    endtask

    task automatic capture_frame(input logic [7:0] cmd, input logic [9:0] addr,
                                 input logic [31:0] data, input bit jam,
                                 input string nm);
        int wbad;
        int sbad;
        int ebad;
        logic [7:0] exp_b;
        wbad = 0;
        sbad = 0;
        ebad = 0;
        for (int c = 0; c < FRAME; c++) begin
            wave[c] = tx;
            if (tx !== model_tx(cmd, addr, data, c)) wbad++;
            if (busy !== 1'b1 || frame_done !== 1'b0 || req_ready !== 1'b0) sbad++;
            if (c > 0 && wave[c] !== wave[c-1] && (c % BD) != 0) ebad++;
            if (jam) begin
                req_valid = 1'b1;
                req_cmd   = 8'($urandom);
                req_addr  = 10'($urandom);
                req_data  = $urandom;
            end
            step();
        end
        req_valid = 1'b0;
        checks++;
        if (wbad != 0) begin
            errors++;
            $display("FAIL %s wave: %0d bad cycles required 0", nm, wbad);
        end
        checks++;
        if (sbad != 0) begin
            errors++;
            $display("FAIL %s busy_flags: %0d bad cycles required 0", nm, sbad);
        end
        checks++;
        if (ebad != 0) begin
            errors++;
            $display("FAIL %s edge_align: %0d off-grid edges required 0", nm, ebad);
        end
        checks++;
        if (frame_done !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b ready=%b busy=%b required 1 1 0",
                     nm, frame_done, req_ready, busy);
        end
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) got[k][i] = wave[(k*10+1+i)*BD + BD/2];
            exp_b = model_byte(cmd, addr, data, k);
            checks++;
            if (got[k] !== exp_b) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h required %02h", nm, k, got[k], exp_b);
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_cmd   = 8'h55;
        req_addr  = 10'h3FF;
        req_data  = 32'h1234_5678;
        repeat (3) step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b ready=%b done=%b required 1 0 1 0",
                     tx, busy, req_ready, frame_done);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority: busy=%b tx=%b required 0 1", busy, tx);
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp_b[9];
        exp_b = '{8'hAA, 8'h02, 8'h01, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h84};
        present(8'h02, 10'h1A5, 32'hDEADBEEF);
        capture_frame(8'h02, 10'h1A5, 32'hDEADBEEF, 1'b0, "basic");
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (got[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL basic_lit%0d: got %02h required %02h", k, got[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_bit_timing;
        logic [9:0] pat;
        logic [7:0] c;
        logic [9:0] w;
        c   = 8'($urandom);
        pat = 10'b11_0101_0100;
        present(c, 10'($urandom), $urandom);
        capture_frame(c, req_addr, req_data, 1'b0, "timing");
        for (int j = 0; j < 10; j++) w[j] = wave[j*BD + BD/2];
        checks++;
        if (w !== pat) begin
            errors++;
            $display("FAIL sync_bits: got %b required %b (bit0 first = rightmost)", w, pat);
        end
    endtask

    task automatic test_random;
        logic [7:0]  c;
        logic [9:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) step();
            c = 8'($urandom);
            a = 10'($urandom);
            d = $urandom;
            present(c, a, d);
            capture_frame(c, a, d, 1'b0, "random");
        end
    endtask

    task automatic test_busy_ignore;
        logic [7:0]  c;
        logic [9:0]  a;
        logic [31:0] d;
        step();
        c = 8'($urandom);
        a = 10'($urandom);
        d = $urandom;
        present(c, a, d);
        capture_frame(c, a, d, 1'b1, "ignore");
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_single: tx=%b busy=%b required 1 0", tx, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [31:0] d1;
        logic [31:0] d2;
        c1 = 8'($urandom);
        c2 = 8'($urandom);
        d1 = $urandom;
        d2 = $urandom;
        present(c1, 10'h0F3, d1);
        capture_frame(c1, 10'h0F3, d1, 1'b0, "b2b_1");
        present(c2, 10'h30C, d2);
        capture_frame(c2, 10'h30C, d2, 1'b0, "b2b_2");
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp_b[9];
        exp_b = '{8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        step();
        present(8'($urandom), 10'($urandom), $urandom);
        repeat (44 * BD + 3) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b busy=%b ready=%b done=%b required 1 0 1 0",
                     tx, busy, req_ready, frame_done);
        end
        present(8'h01, 10'h000, 32'h0);
        capture_frame(8'h01, 10'h000, 32'h0, 1'b0, "after_rst");
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (got[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL after_rst_lit%0d: got %02h required %02h", k, got[k], exp_b[k]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_basic();
        test_bit_timing();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boreal_uart_tx_framer.md
BOREAL_UART_TX_FRAMER -- requirements
Module: boreal_uart_tx_framer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, UART bit rate; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division), legal only when BAUD_DIV >= 2.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  response frame request.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_cmd  input  8  command byte echoed in the frame.
REQ-008 The block SHALL have port req_addr  input  10  MMIO word address.
REQ-009 The block SHALL have port req_data  input  32  MMIO read data.
REQ-010 The block SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-011 The block SHALL have port busy  output  1  frame in transmission.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 Transfer: the block SHALL accept a request on a cycle with req_valid && req_ready, and capture cmd/addr/data in that cycle.
REQ-014 req_ready SHALL equal (state == IDLE); requests while busy SHALL be ignored, not queued.
REQ-015 Frame: the block SHALL send 9 bytes in order: 0xAA, CMD, {6'b0, addr[9:8]}, addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0], CHK.
REQ-016 CHK SHALL be the bytewise XOR of bytes 1..7 (CMD through data[7:0]); 0xAA SHALL be excluded.
REQ-017 Byte format: the block SHALL send start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-018 Each bit SHALL be held on tx for exactly BAUD_DIV cycles.
REQ-019 FSM: the block SHALL implement states IDLE -> START -> DATA (8 bits) -> STOP.
- STOP -> START when byte index < 8, with the index incremented.
- STOP -> IDLE after byte index 8.
REQ-020 Inter-byte gap within a frame SHALL be zero cycles.
REQ-021 Latency: tx SHALL drive the first start bit starting the cycle after acceptance.
REQ-022 Total frame time SHALL be exactly 90 * BAUD_DIV cycles, from that first start-bit cycle through the last stop-bit cycle.
REQ-023 frame_done SHALL pulse high for exactly one cycle, in the cycle the FSM returns to IDLE; req_ready SHALL be high in that same cycle.
REQ-024 Back-to-back operation: a request accepted in the frame_done cycle SHALL start its start bit on the next cycle, giving no idle bits between frames.
REQ-025 busy SHALL be high from the cycle after acceptance until the cycle frame_done is asserted, inclusive of neither.
REQ-026 Capture rule: captured fields SHALL NOT change while busy; changes on req_* inputs during a frame SHALL have no effect.
REQ-027 Counters: the baud counter SHALL be sized for BAUD_DIV - 1 and SHALL wrap only at bit boundaries; the bit index is 3 bits and the byte index is 4 bits.

Reset
REQ-028 On rst = 1 at a clock edge, the block SHALL force state to IDLE, tx = 1, busy = 0, frame_done = 0, req_ready = 1, and clear all counters.
REQ-029 Reset mid-frame SHALL abandon the frame immediately; tx SHALL return high on that edge with no partial stop bit.
REQ-030 The first request after reset release SHALL be accepted normally.
REQ-031 Reset SHALL take priority over a simultaneous req_valid.

Verification
Bench parameters: CLK_FREQ = 1_000_000, BAUD_RATE = 125_000, giving BAUD_DIV = 8.
REQ-032 Basic frame: cmd = 0x02, addr = 0x1A5, data = 0xDEADBEEF.
- Decoded bytes: AA 02 01 A5 DE AD BE EF 84.
- frame_done exactly 720 cycles after the first start-bit cycle.
REQ-033 Bit timing: a single frame -> every tx edge falls on an 8-cycle boundary; start = 0, stop = 1, LSB first for 0xAA (tx pattern 0,0,1,0,1,0,1,0,1,1).
REQ-034 Busy ignore: hold req_valid = 1 with changing data during the frame -> exactly one frame sent, carrying the originally captured data.
REQ-035 Back-to-back: two requests, the second presented in the frame_done cycle -> 18 bytes, no idle-high bit between frame 1 CHK stop bit and frame 2 start bit.
REQ-036 Reset mid-frame: rst asserted during byte 4 bit 3 -> tx = 1, busy = 0, req_ready = 1 next cycle; a new request (cmd 0x01, addr 0x000, data 0x00000000) then yields AA 01 00 00 00 00 00 00 01.
